pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter BUF_WIDTH, default 8: width of one pattern field and of p_drive/n_drive.
REQ-002 Parameter NO_BUFS, default 8: number of pattern buffers, sequenced one-hot.
REQ-003 Parameter N_TWEAK, default 6: number of tweak channels.
REQ-004 Parameter DELAY_W, default 3: per-channel tweak delay width.
REQ-005 Parameter DUR_W, default 2: per-channel tweak duration width.
REQ-006 Parameter DT_W, default 4: dead-time count width.
REQ-007 Derived SA_W = clog2(NO_BUFS); legal only if DELAY_W+DUR_W+2 <= BUF_WIDTH (elaboration error otherwise).
REQ-008 clk  in  1  sole clock, all state on rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 pwm  in  1  phase request; 1 = high-drive (P) phase, 0 = low-drive (N) phase.
REQ-011 enable  in  1  sequencer run; 0 forces IDLE.
REQ-012 dead_cycles  in  DT_W  dead-time extension, sampled on DEAD entry.
REQ-013 seq_mode  in  1  0 = wrap buffer_select after top buffer, 1 = hold at top buffer.
REQ-014 ssel  in  1  direct buffer-select request.
REQ-015 saddr  in  SA_W  buffer index for ssel.
REQ-016 pat_p_word  in  (N_TWEAK+2)*BUF_WIDTH  P-phase fields of selected buffer: [0]=drive, [1]=global delay, [2+k]=tweak k.
REQ-017 pat_n_word  in  (N_TWEAK+2)*BUF_WIDTH  N-phase fields, same layout.
REQ-018 buffer_select  out  NO_BUFS  one-hot buffer pointer to the pattern store.
REQ-019 phase  out  2  00 IDLE, 01 DEAD, 10 DRIVE_P, 11 DRIVE_N.
REQ-020 p_drive  out  BUF_WIDTH  P-side drive, active-low (all-ones = off).
REQ-021 n_drive  out  BUF_WIDTH  N-side drive, active-high (zero = off).
REQ-022 tweak_global_delay  out  BUF_WIDTH  global tweak delay.
REQ-023 tweak_enable, tweak_sense  out  N_TWEAK each  per-channel enable and sense.
REQ-024 tweak_delay  out  N_TWEAK*DELAY_W, tweak_duration  out  N_TWEAK*DUR_W  packed per channel, channel 0 in LSBs.

Function
REQ-025 Tweak field bit map SHALL be: bit0 enable, bits DELAY_W:1 delay, next DUR_W bits duration, next bit sense; remaining bits ignored.
REQ-026 pwm_prev SHALL register pwm every cycle; edge = pwm != pwm_prev.
REQ-027 FSM states SHALL be IDLE, DEAD, DRIVE_P, DRIVE_N.
REQ-028 enable=0 in any state -> IDLE next cycle (highest priority).
REQ-029 IDLE with enable=1 -> DEAD, counter loaded with dead_cycles.
REQ-030 DRIVE_P/DRIVE_N on edge -> DEAD, counter loaded with dead_cycles.
REQ-031 DEAD: edge reloads counter, state stays DEAD; else counter 0 -> DRIVE_P if pwm_prev=1, DRIVE_N if 0, buffer_select <= bit0; else decrement.
REQ-032 Dead time SHALL therefore last dead_cycles+1 cycles minimum; dead_cycles=0 gives exactly one cycle.
REQ-033 In DRIVE states without edge: ssel=1 and saddr<NO_BUFS -> buffer_select <= onehot(saddr); ssel=1 and saddr>=NO_BUFS -> hold.
REQ-034 Otherwise top bit set -> bit0 if seq_mode=0, hold if seq_mode=1; else shift left by one.
REQ-035 buffer_select SHALL hold in IDLE and DEAD except the DEAD-exit load.
REQ-036 Outputs SHALL be registered; field values reflect pat word present in the cycle the FSM is in DRIVE, visible next cycle (latency 1 from buffer_select).
REQ-037 Next-state DRIVE_P (no edge): p_drive=field0 of pat_p_word, n_drive=0, remaining outputs from pat_p_word.
REQ-038 Next-state DRIVE_N (no edge): p_drive=all-ones, n_drive=field0 of pat_n_word, remaining outputs from pat_n_word.
REQ-039 Any cycle where next-state is DEAD or IDLE: p_drive=all-ones, n_drive=0, tweak_enable=0; delay/duration/sense/global delay hold.
REQ-040 p_drive active (not all-ones) and n_drive nonzero SHALL never coexist.

Reset
REQ-041 reset low SHALL asynchronously force: phase=IDLE, buffer_select=bit0, pwm_prev=0, counter=0, p_drive=all-ones, n_drive=0, tweak_global_delay=0, all tweak outputs 0.
REQ-042 Reset release mid-operation SHALL restart via IDLE->DEAD; no output drives before a full dead time.

Verification
REQ-043 Reset with enable=1, pwm=1, dead_cycles=2 -> phase 00,01,01,01,10; p_drive active first cycle after DRIVE_P entry; buffer_select=0x01.
REQ-044 DRIVE_P, seq_mode=0, no ssel, 8 cycles -> buffer_select 0x01..0x80 then 0x01; seq_mode=1 -> holds 0x80.
REQ-045 pwm 1->0 in DRIVE_P, dead_cycles=0 -> one DEAD cycle with p_drive=0xFF, n_drive=0, tweak_enable=0, then DRIVE_N with n_drive=pat_n_word field0.
REQ-046 pwm toggles twice during DEAD (dead_cycles=3) -> counter reloads each edge; DRIVE entered 4 cycles after last edge, phase matches final pwm.
REQ-047 ssel=1, saddr=5 in DRIVE_N -> buffer_select=0x20 next cycle; during DEAD -> ignored.
REQ-048 Tweak field 0x5B on channel 2 in DRIVE_P -> enable=1, delay=5, duration=1, sense=1; enable=0 mid-drive -> outputs off next cycle, phase 00.

Source files
------------

// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//
// Steps through a bank of one-hot selected pattern buffers and turns the
// selected pattern word into complementary P/N drive plus per-channel tweak
// controls. Every phase change passes through a dead time of at least
// dead_cycles+1 cycles during which both drive sides are off.
//
// Handshake: there is none. The pattern store is a combinational lookup
// addressed by buffer_select; pat_p_word/pat_n_word are sampled every cycle.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-low
//   pwm                 phase request (1 = P phase, 0 = N phase)
//   enable              run; 0 forces IDLE on the next edge
//   dead_cycles         dead-time extension, loaded on DEAD entry/re-entry
//   seq_mode            0 = wrap buffer pointer, 1 = hold at top buffer
//   ssel, saddr         direct buffer-select request
//   pat_p_word          P-phase fields: [0]=drive, [1]=global delay, [2+k]=tweak k
//   pat_n_word          N-phase fields, same layout
//   buffer_select       one-hot buffer pointer to the pattern store
//   phase               FSM state: 00 IDLE, 01 DEAD, 10 DRIVE_P, 11 DRIVE_N
//   p_drive             P-side drive, active-low (all-ones = off)
//   n_drive             N-side drive, active-high (zero = off)
//   tweak_global_delay  global tweak delay
//   tweak_enable/sense  per-channel enable and sense
//   tweak_delay         per-channel delay, channel 0 in LSBs
//   tweak_duration      per-channel duration, channel 0 in LSBs
module pattern_sequencer #(
    parameter int BUF_WIDTH = 8,
    parameter int NO_BUFS   = 8,
    parameter int N_TWEAK   = 6,
    parameter int DELAY_W   = 3,
    parameter int DUR_W     = 2,
    parameter int DT_W      = 4,
    parameter int SA_W      = $clog2(NO_BUFS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pwm,
    input  logic                           enable,
    input  logic [DT_W-1:0]                dead_cycles,
    input  logic                           seq_mode,
    input  logic                           ssel,
    input  logic [SA_W-1:0]                saddr,
    input  logic [(N_TWEAK+2)*BUF_WIDTH-1:0] pat_p_word,
    input  logic [(N_TWEAK+2)*BUF_WIDTH-1:0] pat_n_word,
    output logic [NO_BUFS-1:0]             buffer_select,
    output logic [1:0]                     phase,
    output logic [BUF_WIDTH-1:0]           p_drive,
    output logic [BUF_WIDTH-1:0]           n_drive,
    output logic [BUF_WIDTH-1:0]           tweak_global_delay,
    output logic [N_TWEAK-1:0]             tweak_enable,
    output logic [N_TWEAK-1:0]             tweak_sense,
    output logic [N_TWEAK*DELAY_W-1:0]     tweak_delay,
    output logic [N_TWEAK*DUR_W-1:0]       tweak_duration
);

    // A tweak field holds enable, delay, duration and sense packed from bit 0.
    if (DELAY_W + DUR_W + 2 > BUF_WIDTH) begin : g_bad_field_map
        $error("pattern_sequencer: DELAY_W+DUR_W+2 exceeds BUF_WIDTH");
    end
    if (NO_BUFS < 2) begin : g_bad_no_bufs
        $error("pattern_sequencer: NO_BUFS must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DEAD    = 2'b01,
        DRIVE_P = 2'b10,
        DRIVE_N = 2'b11
    } state_t;

    localparam logic [NO_BUFS-1:0] FIRST_BUF = {{(NO_BUFS-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic               pwm_prev;
    logic [DT_W-1:0]    cnt, cnt_nxt;
    logic [NO_BUFS-1:0] bs_nxt;
    logic               pwm_edge;
    logic               saddr_ok;

    logic [(N_TWEAK+2)*BUF_WIDTH-1:0] sel_word;
    logic [BUF_WIDTH-1:0]             p_nxt, n_nxt, gdel_nxt;
    logic [N_TWEAK-1:0]               ten_nxt, tsen_nxt;
    logic [N_TWEAK*DELAY_W-1:0]       tdel_nxt;
    logic [N_TWEAK*DUR_W-1:0]         tdur_nxt;

    // Bits of the tweak fields above the sense bit carry no meaning.
    logic unused_bits;
    assign unused_bits = ^sel_word;

    assign phase    = state;
    assign pwm_edge = (pwm != pwm_prev);

    // With a power-of-two buffer count every saddr value is a real buffer.
    if (NO_BUFS == (1 << SA_W)) begin : g_saddr_full
        assign saddr_ok = 1'b1;
    end else begin : g_saddr_range
        assign saddr_ok = (32'(saddr) < 32'(NO_BUFS));
    end

    // Next-state, dead-time counter and buffer pointer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bs_nxt    = buffer_select;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = DEAD;
                    cnt_nxt   = dead_cycles;
                end
                DEAD: begin
                    if (pwm_edge) begin
                        // A late edge restarts the whole dead time.
                        cnt_nxt = dead_cycles;
                    end else if (cnt == '0) begin
                        state_nxt = pwm_prev ? DRIVE_P : DRIVE_N;
                        bs_nxt    = FIRST_BUF;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                default: begin // DRIVE_P, DRIVE_N
                    if (pwm_edge) begin
                        state_nxt = DEAD;
                        cnt_nxt   = dead_cycles;
                    end else if (ssel) begin
                        if (saddr_ok) begin
                            bs_nxt = FIRST_BUF << saddr;
                        end
                    end else if (buffer_select[NO_BUFS-1]) begin
                        if (!seq_mode) begin
                            bs_nxt = FIRST_BUF;
                        end
                    end else begin
                        bs_nxt = buffer_select << 1;
                    end
                end
            endcase
        end
    end

    // Output values are chosen from the state being entered, so drive and
    // phase change on the same edge and drive is always off when the next
    // state is DEAD or IDLE.
    always_comb begin
        sel_word = (state_nxt == DRIVE_N) ? pat_n_word : pat_p_word;
        p_nxt    = '1;
        n_nxt    = '0;
        ten_nxt  = '0;
        gdel_nxt = tweak_global_delay;
        tsen_nxt = tweak_sense;
        tdel_nxt = tweak_delay;
        tdur_nxt = tweak_duration;
        if (state_nxt == DRIVE_P || state_nxt == DRIVE_N) begin
            if (state_nxt == DRIVE_P) begin
                p_nxt = sel_word[BUF_WIDTH-1:0];
            end else begin
                n_nxt = sel_word[BUF_WIDTH-1:0];
            end
            gdel_nxt = sel_word[BUF_WIDTH +: BUF_WIDTH];
            for (int k = 0; k < N_TWEAK; k++) begin
                ten_nxt[k]                    = sel_word[(2+k)*BUF_WIDTH];
                tdel_nxt[k*DELAY_W +: DELAY_W] = sel_word[(2+k)*BUF_WIDTH + 1 +: DELAY_W];
                tdur_nxt[k*DUR_W +: DUR_W]     = sel_word[(2+k)*BUF_WIDTH + 1 + DELAY_W +: DUR_W];
                tsen_nxt[k]                   = sel_word[(2+k)*BUF_WIDTH + 1 + DELAY_W + DUR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            pwm_prev           <= 1'b0;
            cnt                <= '0;
            buffer_select      <= FIRST_BUF;
            p_drive            <= '1;
            n_drive            <= '0;
            tweak_global_delay <= '0;
            tweak_enable       <= '0;
            tweak_sense        <= '0;
            tweak_delay        <= '0;
            tweak_duration     <= '0;
        end else begin
            state              <= state_nxt;
            pwm_prev           <= pwm;
            cnt                <= cnt_nxt;
            buffer_select      <= bs_nxt;
            p_drive            <= p_nxt;
            n_drive            <= n_nxt;
            tweak_global_delay <= gdel_nxt;
            tweak_enable       <= ten_nxt;
            tweak_sense        <= tsen_nxt;
            tweak_delay        <= tdel_nxt;
            tweak_duration     <= tdur_nxt;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer with default parameters.
// Inputs change on the falling clock edge; outputs are checked on the
// following falling edge, one rising edge later.
module tb_pattern_sequencer;

    logic        clk;
    logic        reset;
    logic        pwm;
    logic        enable;
    logic [3:0]  dead_cycles;
    logic        seq_mode;
    logic        ssel;
    logic [2:0]  saddr;
    logic [63:0] pat_p_word;
    logic [63:0] pat_n_word;
    logic [7:0]  buffer_select;
    logic [1:0]  phase;
    logic [7:0]  p_drive;
    logic [7:0]  n_drive;
    logic [7:0]  tweak_global_delay;
    logic [5:0]  tweak_enable;
    logic [5:0]  tweak_sense;
    logic [17:0] tweak_delay;
    logic [11:0] tweak_duration;

    int checks   = 0;
    int failures = 0;

    pattern_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .pwm                (pwm),
        .enable             (enable),
        .dead_cycles        (dead_cycles),
        .seq_mode           (seq_mode),
        .ssel               (ssel),
        .saddr              (saddr),
        .pat_p_word         (pat_p_word),
        .pat_n_word         (pat_n_word),
        .buffer_select      (buffer_select),
        .phase              (phase),
        .p_drive            (p_drive),
        .n_drive            (n_drive),
        .tweak_global_delay (tweak_global_delay),
        .tweak_enable       (tweak_enable),
        .tweak_sense        (tweak_sense),
        .tweak_delay        (tweak_delay),
        .tweak_duration     (tweak_duration)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // P word: drive A5, global 33, ch0=0x01, ch2=0x5B (en, delay 5, dur 1, sense)
    // N word: drive 3C, global 44, ch0=0x7F (en, delay 7, dur 3, sense)
    task automatic check_p_outputs(input string tag);
        check({tag, ".p_drive"}, 32'(p_drive), 32'hA5);
        check({tag, ".n_drive"}, 32'(n_drive), 32'h00);
        check({tag, ".gdelay"},  32'(tweak_global_delay), 32'h33);
        check({tag, ".t_en"},    32'(tweak_enable), 32'b000101);
        check({tag, ".t_sense"}, 32'(tweak_sense), 32'b000100);
        check({tag, ".t_delay"}, 32'(tweak_delay), 32'h00140);
        check({tag, ".t_dur"},   32'(tweak_duration), 32'h010);
    endtask

    task automatic check_n_outputs(input string tag);
        check({tag, ".p_drive"}, 32'(p_drive), 32'hFF);
        check({tag, ".n_drive"}, 32'(n_drive), 32'h3C);
        check({tag, ".gdelay"},  32'(tweak_global_delay), 32'h44);
        check({tag, ".t_en"},    32'(tweak_enable), 32'b000001);
        check({tag, ".t_sense"}, 32'(tweak_sense), 32'b000001);
        check({tag, ".t_delay"}, 32'(tweak_delay), 32'h00007);
        check({tag, ".t_dur"},   32'(tweak_duration), 32'h003);
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b1;
        pwm         = 1'b1;
        dead_cycles = 4'd2;
        seq_mode    = 1'b0;
        ssel        = 1'b0;
        saddr       = 3'd0;
        pat_p_word  = {8'h00, 8'h00, 8'h00, 8'h5B, 8'h00, 8'h01, 8'h33, 8'hA5};
        pat_n_word  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h44, 8'h3C};

        // Reset state
        tick();
        tick();
        check("rst.phase",   32'(phase), 32'h0);
        check("rst.bsel",    32'(buffer_select), 32'h01);
        check("rst.p_drive", 32'(p_drive), 32'hFF);
        check("rst.n_drive", 32'(n_drive), 32'h00);
        check("rst.t_en",    32'(tweak_enable), 32'h0);
        check("rst.t_delay", 32'(tweak_delay), 32'h0);
        check("rst.gdelay",  32'(tweak_global_delay), 32'h0);

        // Release with dead_cycles=2: three DEAD cycles then DRIVE_P
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("start.dead_phase", 32'(phase), 32'h1);
            check("start.dead_p_off", 32'(p_drive), 32'hFF);
        end
        tick();
        check("start.phase", 32'(phase), 32'h2);
        check("start.bsel",  32'(buffer_select), 32'h01);
        check_p_outputs("drive_p");

        // Walk all buffers with wrap
        for (int i = 1; i < 8; i++) begin
            tick();
            check("wrap.bsel", 32'(buffer_select), 32'(8'h01 << i));
        end
        tick();
        check("wrap.bsel_back", 32'(buffer_select), 32'h01);

        // Hold at top buffer
        seq_mode = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("hold.bsel_top", 32'(buffer_select), 32'h80);
        tick();
        tick();
        check("hold.bsel_held", 32'(buffer_select), 32'h80);
        check("hold.phase", 32'(phase), 32'h2);

        // P -> N with one dead cycle; ssel during DEAD is ignored
        dead_cycles = 4'd0;
        pwm   = 1'b0;
        ssel  = 1'b1;
        saddr = 3'd5;
        tick();
        check("pn.dead_phase",  32'(phase), 32'h1);
        check("pn.dead_p",      32'(p_drive), 32'hFF);
        check("pn.dead_n",      32'(n_drive), 32'h00);
        check("pn.dead_t_en",   32'(tweak_enable), 32'h0);
        check("pn.dead_gdelay", 32'(tweak_global_delay), 32'h33);
        check("pn.dead_t_del",  32'(tweak_delay), 32'h00140);
        check("pn.dead_bsel",   32'(buffer_select), 32'h80);
        tick();
        check("pn.phase", 32'(phase), 32'h3);
        check("pn.bsel",  32'(buffer_select), 32'h01);
        check_n_outputs("drive_n");

        // Direct select in DRIVE_N
        tick();
        check("ssel.bsel", 32'(buffer_select), 32'h20);
        ssel = 1'b0;
        tick();
        check("ssel.shift", 32'(buffer_select), 32'h40);

        // Edges inside DEAD reload the counter (dead_cycles=3)
        dead_cycles = 4'd3;
        pwm = 1'b1;
        tick();
        check("redge.enter", 32'(phase), 32'h1);
        tick();
        pwm = 1'b0;
        tick();
        check("redge.edge1", 32'(phase), 32'h1);
        pwm = 1'b1;
        tick();
        check("redge.edge2", 32'(phase), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("redge.dead", 32'(phase), 32'h1);
            check("redge.n_off", 32'(n_drive), 32'h00);
        end
        tick();
        check("redge.phase", 32'(phase), 32'h2);
        check("redge.p_drive", 32'(p_drive), 32'hA5);

        // Disable mid-drive
        enable = 1'b0;
        tick();
        check("dis.phase",   32'(phase), 32'h0);
        check("dis.p_drive", 32'(p_drive), 32'hFF);
        check("dis.n_drive", 32'(n_drive), 32'h00);
        check("dis.t_en",    32'(tweak_enable), 32'h0);
        check("dis.t_delay", 32'(tweak_delay), 32'h00140);
        enable = 1'b1;
        tick();
        check("reen.phase", 32'(phase), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        check("reen.drive", 32'(phase), 32'h2);

        // Asynchronous reset mid-drive, then restart through dead time
        #2;
        reset = 1'b0;
        #1;
        check("arst.phase",   32'(phase), 32'h0);
        check("arst.p_drive", 32'(p_drive), 32'hFF);
        check("arst.bsel",    32'(buffer_select), 32'h01);
        check("arst.t_dur",   32'(tweak_duration), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("arst.restart_dead", 32'(phase), 32'h1);
        check("arst.restart_p",    32'(p_drive), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
